// File: rtl/forwarding_source_jmp.sv
// rtl/forwarding_source_jmp.sv - two-stage write-forwarding source with load-use jump stall
//
// Purpose: keeps the two most recent register writes (capture stage BUS/LD_reg and
// past stage BUS_past/LD_reg_past) so a register-indirect jump can pick up its
// target before writeback. A load's data arrives one cycle after capture; while
// it is outstanding, a jump that names the load's destination raises STALL.
//
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   EN                 pipeline advance (0 holds the stages and the FSM)
//   FLUSH              jump taken; kills the write presented this cycle
//   WB_VALID/WB_DST    write presented this cycle and its destination (0=A..3=D)
//   WB_DATA            ALU result for a non-load write
//   WB_IS_LOAD         write data comes from MEM_DATA on the following cycle
//   MEM_DATA           memory read data for the outstanding load
//   JUMP_REQ/JSEL      register-indirect jump decoding; JSEL 0-3 = A-D, 4-7 = none
//   BUS/LD_reg         newest forwarded value and its one-hot destination
//   BUS_past/LD_reg_past previous forwarded value and its one-hot destination
//   STALL              hold the front end for one cycle
module forwarding_source_jmp (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        FLUSH,
  input  logic        WB_VALID,
  input  logic [1:0]  WB_DST,
  input  logic [15:0] WB_DATA,
  input  logic        WB_IS_LOAD,
  input  logic [15:0] MEM_DATA,
  input  logic        JUMP_REQ,
  input  logic [2:0]  JSEL,
  output logic [15:0] BUS,
  output logic [3:0]  LD_reg,
  output logic [15:0] BUS_past,
  output logic [3:0]  LD_reg_past,
  output logic        STALL
);

  typedef enum logic {IDLE = 1'b0, LOAD_PEND = 1'b1} state_t;

  state_t state, state_n;

  // Register A maps to the MSB of the one-hot code.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b1000 >> idx;
  endfunction

  logic capture;
  logic load_cap;
  logic alu_cap;
  logic pending;

  assign capture  = EN && WB_VALID && !FLUSH;
  assign load_cap = capture && WB_IS_LOAD;
  assign alu_cap  = capture && !WB_IS_LOAD;
  assign pending  = (state == LOAD_PEND);

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state: an outstanding load always resolves on the next edge,
  // even when EN is low, because MEM_DATA is only valid for that one cycle.
  always_comb begin
    state_n = state;
    if (EN)           state_n = load_cap ? LOAD_PEND : IDLE;
    else if (pending) state_n = IDLE;
  end

  // FSM output: the jump needs the load result that has not arrived yet.
  always_comb begin
    STALL = 1'b0;
    if (pending && JUMP_REQ && !JSEL[2] && (onehot(JSEL[1:0]) == LD_reg))
      STALL = 1'b1;
  end

  // Capture stage data. A load resolving on an EN edge also hands MEM_DATA
  // straight to the past stage, so a new ALU write may take BUS that edge
  // without losing the load value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUS <= 16'h0000;
    end else if (alu_cap) begin
      BUS <= WB_DATA;
    end else if (pending) begin
      BUS <= MEM_DATA;
    end
  end

  // Destination codes and past stage advance only with EN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LD_reg      <= 4'b0000;
      LD_reg_past <= 4'b0000;
      BUS_past    <= 16'h0000;
    end else if (EN) begin
      LD_reg_past <= LD_reg;
      BUS_past    <= pending ? MEM_DATA : BUS;
      LD_reg      <= capture ? onehot(WB_DST) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_forwarding_source_jmp.sv
// tb/tb_forwarding_source_jmp.sv - scoreboard bench for forwarding_source_jmp
module tb_forwarding_source_jmp;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b0;
  logic        FLUSH = 1'b0;
  logic        WB_VALID = 1'b0;
  logic [1:0]  WB_DST = 2'd0;
  logic [15:0] WB_DATA = 16'h0;
  logic        WB_IS_LOAD = 1'b0;
  logic [15:0] MEM_DATA = 16'h0;
  logic        JUMP_REQ = 1'b0;
  logic [2:0]  JSEL = 3'd0;
  logic [15:0] BUS;
  logic [3:0]  LD_reg;
  logic [15:0] BUS_past;
  logic [3:0]  LD_reg_past;
  logic        STALL;

  forwarding_source_jmp dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .FLUSH(FLUSH), .WB_VALID(WB_VALID),
    .WB_DST(WB_DST), .WB_DATA(WB_DATA), .WB_IS_LOAD(WB_IS_LOAD), .MEM_DATA(MEM_DATA),
    .JUMP_REQ(JUMP_REQ), .JSEL(JSEL), .BUS(BUS), .LD_reg(LD_reg), .BUS_past(BUS_past),
    .LD_reg_past(LD_reg_past), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        en;
    logic        flush;
    logic        wv;
    logic [1:0]  dst;
    logic [15:0] data;
    logic        is_load;
    logic [15:0] mem;
    logic        jreq;
    logic [2:0]  jsel;
  } stim_t;

  // stall is sampled mid-cycle before the edge, registers just after the edge
  typedef struct packed {
    logic        stall;
    logic [15:0] bus;
    logic [3:0]  ld;
    logic [15:0] bus_past;
    logic [3:0]  ld_past;
  } obs_t;

  obs_t  sb[$];
  stim_t st[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  function automatic stim_t mk(input logic en, input logic flush, input logic wv,
                               input logic [1:0] dst, input logic [15:0] data,
                               input logic is_load, input logic [15:0] mem,
                               input logic jreq, input logic [2:0] jsel);
    mk = '{en, flush, wv, dst, data, is_load, mem, jreq, jsel};
  endfunction

  function automatic obs_t ex(input logic stall, input logic [15:0] bus, input logic [3:0] ld,
                              input logic [15:0] bus_past, input logic [3:0] ld_past);
    ex = '{stall, bus, ld, bus_past, ld_past};
  endfunction

  function automatic obs_t sample();
    sample = '{STALL, BUS, LD_reg, BUS_past, LD_reg_past};
  endfunction

  task automatic drive(input stim_t s);
    EN = s.en; FLUSH = s.flush; WB_VALID = s.wv; WB_DST = s.dst; WB_DATA = s.data;
    WB_IS_LOAD = s.is_load; MEM_DATA = s.mem; JUMP_REQ = s.jreq; JSEL = s.jsel;
  endtask

  // Called just after a rising edge: drive, sample STALL at the falling edge,
  // then sample the registers just after the next rising edge.
  task automatic do_cycle(input stim_t s, output obs_t o);
    logic stall_seen;
    drive(s);
    @(negedge CLK);
    stall_seen = STALL;
    @(posedge CLK);
    #1;
    o = sample();
    o.stall = stall_seen;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    drive(mk(1, 0, 1, 2'd1, 16'h7777, 0, 16'h1111, 1, 3'd1));
    repeat (3) @(posedge CLK);
    #1;
    sb.push_back(ex(0, 16'h0, 4'h0, 16'h0, 4'h0));
    got = sample(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL reset_hold got=%h exp=%h", got, exp);
    end
    drive(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'h0, 0, 3'd0));
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    sb.push_back(ex(0, 16'h0, 4'h0, 16'h0, 4'h0));
    got = sample(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL reset_release got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_alu_forward();
    obs_t got, exp;
    st.push_back(mk(1, 0, 1, 2'd1, 16'h1234, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h1234, 4'b0100, 16'h0000, 4'b0000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0,    0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h1234, 4'b0000, 16'h1234, 4'b0100));
    st.push_back(mk(1, 0, 1, 2'd3, 16'hAAAA, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'hAAAA, 4'b0001, 16'h1234, 4'b0000));
    st.push_back(mk(1, 0, 1, 2'd0, 16'h5555, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h5555, 4'b1000, 16'hAAAA, 4'b0001));
    st.push_back(mk(1, 0, 1, 2'd0, 16'h6666, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h6666, 4'b1000, 16'h5555, 4'b1000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0,    0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h6666, 4'b0000, 16'h6666, 4'b1000));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL alu_forward[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_flush();
    obs_t got, exp;
    st.push_back(mk(1, 1, 1, 2'd3, 16'h9999, 0, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'h6666, 4'b0000, 16'h6666, 4'b0000));
    st.push_back(mk(1, 1, 1, 2'd2, 16'h0,    1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'h6666, 4'b0000, 16'h6666, 4'b0000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0,    0, 16'hDEAD, 1, 3'd2)); sb.push_back(ex(0, 16'h6666, 4'b0000, 16'h6666, 4'b0000));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL flush[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_load_use_jump();
    obs_t got, exp;
    st.push_back(mk(1, 0, 1, 2'd2, 16'h1111, 1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'h6666, 4'b0010, 16'h6666, 4'b0000));
    st.push_back(mk(0, 0, 0, 2'd0, 16'h0,    0, 16'hBEEF, 1, 3'd2)); sb.push_back(ex(1, 16'hBEEF, 4'b0010, 16'h6666, 4'b0000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0,    0, 16'h0,    1, 3'd2)); sb.push_back(ex(0, 16'hBEEF, 4'b0000, 16'hBEEF, 4'b0010));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL load_use_jump[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back_loads();
    obs_t got, exp;
    st.push_back(mk(1, 0, 1, 2'd1, 16'h0, 1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'hBEEF, 4'b0100, 16'hBEEF, 4'b0000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'hCAFE, 0, 3'd0)); sb.push_back(ex(0, 16'hCAFE, 4'b0000, 16'hCAFE, 4'b0100));
    st.push_back(mk(1, 0, 1, 2'd0, 16'h0, 1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'hCAFE, 4'b1000, 16'hCAFE, 4'b0000));
    st.push_back(mk(1, 0, 1, 2'd3, 16'h0, 1, 16'h1357, 0, 3'd0)); sb.push_back(ex(0, 16'h1357, 4'b0001, 16'h1357, 4'b1000));
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'h2468, 1, 3'd3)); sb.push_back(ex(1, 16'h2468, 4'b0000, 16'h2468, 4'b0001));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL back_to_back_loads[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_unrelated_jump();
    obs_t got, exp;
    st.push_back(mk(1, 0, 1, 2'd2, 16'h0, 1, 16'h0,    1, 3'd2)); sb.push_back(ex(0, 16'h2468, 4'b0010, 16'h2468, 4'b0000));
    st.push_back(mk(0, 0, 0, 2'd0, 16'h0, 0, 16'h0A0A, 1, 3'd0)); sb.push_back(ex(0, 16'h0A0A, 4'b0010, 16'h2468, 4'b0000));
    st.push_back(mk(1, 0, 1, 2'd2, 16'h0, 1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'h0A0A, 4'b0010, 16'h0A0A, 4'b0010));
    st.push_back(mk(0, 0, 0, 2'd0, 16'h0, 0, 16'h0B0B, 1, 3'd6)); sb.push_back(ex(0, 16'h0B0B, 4'b0010, 16'h0A0A, 4'b0010));
    st.push_back(mk(1, 0, 1, 2'd2, 16'h0, 1, 16'h0,    0, 3'd0)); sb.push_back(ex(0, 16'h0B0B, 4'b0010, 16'h0B0B, 4'b0010));
    st.push_back(mk(0, 0, 0, 2'd0, 16'h0, 0, 16'h0C0C, 1, 3'd5)); sb.push_back(ex(0, 16'h0C0C, 4'b0010, 16'h0B0B, 4'b0010));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL unrelated_jump[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall_hold();
    obs_t got, exp;
    st.push_back(mk(1, 0, 1, 2'd0, 16'h0005, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h0005, 4'b1000, 16'h0C0C, 4'b0010));
    for (int k = 0; k < 3; k++) begin
      st.push_back(mk(0, 0, 1, 2'd3, 16'hFFFF, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h0005, 4'b1000, 16'h0C0C, 4'b0010));
    end
    st.push_back(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'h0, 0, 3'd0)); sb.push_back(ex(0, 16'h0005, 4'b0000, 16'h0005, 4'b1000));
    for (int i = 0; st.size() > 0; i++) begin
      do_cycle(st.pop_front(), got); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    obs_t got, exp;
    do_cycle(mk(1, 0, 1, 2'd3, 16'h0, 1, 16'h0, 0, 3'd0), got);
    sb.push_back(ex(0, 16'h0005, 4'b0001, 16'h0005, 4'b0000));
    exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL rif_capture got=%h exp=%h", got, exp);
    end
    drive(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'hABCD, 1, 3'd3));
    #2;
    sb.push_back(ex(1, 16'h0005, 4'b0001, 16'h0005, 4'b0000));
    got = sample(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL rif_pending_stall got=%h exp=%h", got, exp);
    end
    RST_N = 1'b0;
    #1;
    sb.push_back(ex(0, 16'h0, 4'h0, 16'h0, 4'h0));
    got = sample(); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL rif_async_clear got=%h exp=%h", got, exp);
    end
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    do_cycle(mk(1, 0, 0, 2'd0, 16'h0, 0, 16'hABCD, 1, 3'd3), got);
    sb.push_back(ex(0, 16'h0, 4'h0, 16'h0, 4'h0));
    exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL rif_no_late_update got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_flush();
    test_load_use_jump();
    test_back_to_back_loads();
    test_unrelated_jump();
    test_stall_hold();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
